// File: rtl/p23_amo_sequencer_if.sv
// Atomic sequencer bundle: core request/response, memory bus, shared ALU.
// master = sequencer side, slave = core/memory/ALU side.
interface p23_amo_sequencer_if #(
  parameter int ALU_CTRL_WIDTH = 5
);
  logic                      req_valid;
  logic                      req_ready;
  logic [4:0]                req_funct5;
  logic [31:0]               req_addr;
  logic [31:0]               req_rs2;
  logic                      rsp_valid;
  logic [31:0]               rsp_data;
  logic                      rsp_err;
  logic                      mem_valid;
  logic                      mem_ready;
  logic [31:0]               mem_addr;
  logic [3:0]                mem_wstrb;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;
  logic [31:0]               alu_a;
  logic [31:0]               alu_b;
  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
  logic [31:0]               alu_result;
  logic                      resv_clear;

  modport master (
    input  req_valid, req_funct5, req_addr, req_rs2,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result,
    input  resv_clear
  );

  modport slave (
    output req_valid, req_funct5, req_addr, req_rs2,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result,
    output resv_clear
  );
endinterface

// File: rtl/p23_amo_sequencer.sv
// RV32A sequencer: AMO read-modify-write, LR/SC with one reservation.
// Ports: clk, resetn (sync, active-low), bus (p23_amo_sequencer_if.master).
module p23_amo_sequencer #(
  parameter int ALU_CTRL_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  p23_amo_sequencer_if.master  bus
);
  typedef logic [ALU_CTRL_WIDTH-1:0] ctrl_t;

  localparam ctrl_t ALU_CTRL_ADD_ADDI = ctrl_t'(0);
  localparam ctrl_t ALU_CTRL_XOR_XORI = ctrl_t'(4);
  localparam ctrl_t ALU_CTRL_OR_ORI   = ctrl_t'(5);
  localparam ctrl_t ALU_CTRL_AND_ANDI = ctrl_t'(6);
  localparam ctrl_t ALU_CTRL_LUI      = ctrl_t'(10);
  localparam ctrl_t ALU_CTRL_MIN      = ctrl_t'(16);
  localparam ctrl_t ALU_CTRL_MAX      = ctrl_t'(17);
  localparam ctrl_t ALU_CTRL_MINU     = ctrl_t'(18);
  localparam ctrl_t ALU_CTRL_MAXU     = ctrl_t'(19);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CALC, S_WR, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    K_AMO, K_LR, K_SC
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  ctrl_t       op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] old_q, old_d;
  logic [31:0] new_q, new_d;
  logic        err_q, err_d;
  logic        resv_v_q, resv_v_d;
  logic [29:0] resv_addr_q, resv_addr_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  ctrl_t       alu_ctrl_q, alu_ctrl_d;

  logic  dec_ok;
  kind_t dec_kind;
  ctrl_t dec_op;

  always_comb begin
    dec_ok   = 1'b1;
    dec_kind = K_AMO;
    dec_op   = ALU_CTRL_ADD_ADDI;
    unique case (bus.req_funct5)
      5'b00000: dec_op = ALU_CTRL_ADD_ADDI;
      5'b00001: dec_op = ALU_CTRL_LUI;
      5'b00100: dec_op = ALU_CTRL_XOR_XORI;
      5'b01000: dec_op = ALU_CTRL_OR_ORI;
      5'b01100: dec_op = ALU_CTRL_AND_ANDI;
      5'b10000: dec_op = ALU_CTRL_MIN;
      5'b10100: dec_op = ALU_CTRL_MAX;
      5'b11000: dec_op = ALU_CTRL_MINU;
      5'b11100: dec_op = ALU_CTRL_MAXU;
      5'b00010: dec_kind = K_LR;
      5'b00011: dec_kind = K_SC;
      default:  dec_ok = 1'b0;
    endcase
  end

  logic misal;
  logic sc_hit;
  assign misal  = bus.req_addr[1:0] != 2'b00;
  assign sc_hit = resv_v_q &&
                  (resv_addr_q == bus.req_addr[31:2]);

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rs2_d       = rs2_q;
    old_d       = old_q;
    new_d       = new_q;
    err_d       = err_q;
    resv_v_d    = resv_v_q;
    resv_addr_d = resv_addr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          kind_d = dec_kind;
          op_d   = dec_op;
          addr_d = bus.req_addr;
          rs2_d  = bus.req_rs2;
          err_d  = 1'b0;
          if (!dec_ok || misal) begin
            // rejected: reservation untouched
            err_d   = 1'b1;
            old_d   = 32'd0;
            state_d = S_RESP;
          end else if (dec_kind == K_SC) begin
            resv_v_d = 1'b0;
            if (sc_hit) begin
              new_d   = bus.req_rs2;
              old_d   = 32'd0;
              state_d = S_WR;
            end else begin
              old_d   = 32'd1;
              state_d = S_RESP;
            end
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (bus.mem_ready) begin
          old_d = bus.mem_rdata;
          if (kind_q == K_LR) begin
            resv_v_d    = 1'b1;
            resv_addr_d = addr_q[31:2];
            state_d     = S_RESP;
          end else begin
            // ALU operands are registered, so load them
            // on the way into CALC
            alu_a_d    = bus.mem_rdata;
            alu_b_d    = rs2_q;
            alu_ctrl_d = op_q;
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        new_d   = bus.alu_result;
        state_d = S_WR;
      end
      S_WR: begin
        if (bus.mem_ready) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // clear beats a same-cycle LR set
    if (bus.resv_clear) resv_v_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      kind_q      <= K_AMO;
      op_q        <= ALU_CTRL_ADD_ADDI;
      addr_q      <= 32'd0;
      rs2_q       <= 32'd0;
      old_q       <= 32'd0;
      new_q       <= 32'd0;
      err_q       <= 1'b0;
      resv_v_q    <= 1'b0;
      resv_addr_q <= 30'd0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_ctrl_q  <= ALU_CTRL_ADD_ADDI;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      old_q       <= old_d;
      new_q       <= new_d;
      err_q       <= err_d;
      resv_v_q    <= resv_v_d;
      resv_addr_q <= resv_addr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) && resetn;
  assign bus.rsp_valid = state_q == S_RESP;
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_data  = (state_q == S_RESP) ? old_q : 32'd0;
  assign bus.mem_valid = (state_q == S_RD) ||
                         (state_q == S_WR);
  assign bus.mem_wstrb = (state_q == S_WR) ? 4'hF : 4'h0;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = new_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
endmodule

// File: doc/p23_amo_sequencer.md
# p23_amo_sequencer

Multi-cycle sequencer for RV32A atomics (AMO*.W, LR.W, SC.W) in the kianV SoC. Accepts one atomic request from the core, performs the memory read, drives the shared ALU (`a`, `b`, `alucontrol`) to compute the new value, writes it back, and returns the old value (or SC status) for rd. It owns the single LR/SC reservation register.

## Interface
- `ALU_CTRL_WIDTH`, default from `riscv_defines.vh`: width of `alu_ctrl`; the encodings are the `ALU_CTRL_*` macros.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous reset, active-low.
- `req_valid`  in  1  atomic request present.
- `req_ready`  out  1  sequencer idle and able to accept.
- `req_funct5`  in  5  instr[31:27].
- `req_addr`  in  32  rs1 value, the word address.
- `req_rs2`  in  32  rs2 operand.
- `rsp_valid`  out  1  one-cycle pulse: result available.
- `rsp_data`  out  32  rd write value.
- `rsp_err`  out  1  qualifies `rsp_valid`: misaligned address or unsupported funct5.
- `mem_valid`  out  1  memory request.
- `mem_ready`  in  1  memory completes the request this cycle.
- `mem_addr`  out  32  word address.
- `mem_wstrb`  out  4  4'h0 = read, 4'hF = write.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid when `mem_ready` is high.
- `alu_a`  out  32  ALU operand a.
- `alu_b`  out  32  ALU operand b.
- `alu_ctrl`  out  `ALU_CTRL_WIDTH`  ALU opcode.
- `alu_result`  in  32  combinational ALU result.
- `resv_clear`  in  1  invalidate the reservation (trap, or a store from another master to any address).

## Operation
- States: IDLE, RD, CALC, WR, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch funct5, addr and rs2, then decode.
- Decode map, funct5 to ALU ctrl:
  - 00000 ADD_ADDI
  - 00001 SWAP, uses LUI (result=b)
  - 00100 XOR_XORI
  - 01000 OR_ORI
  - 01100 AND_ANDI
  - 10000 MIN
  - 10100 MAX
  - 11000 MINU
  - 11100 MAXU
  - 00010 LR
  - 00011 SC
- Errors: any other funct5, or addr[1:0]≠0, goes IDLE→RESP.
  - `rsp_err`=1, `rsp_data`=0.
  - No memory access; reservation unchanged.
- AMO: IDLE→RD→CALC→WR→RESP→IDLE.
  - RD: `mem_valid`=1, `mem_wstrb`=0, held until `mem_ready`; on `mem_ready` latch `old_q`=`mem_rdata`.
  - CALC (exactly 1 cycle): `alu_a`=`old_q`, `alu_b`=`rs2_q`, `alu_ctrl`=decoded op; latch `new_q`=`alu_result`.
  - WR: `mem_valid`=1, `mem_wstrb`=4'hF, `mem_wdata`=`new_q`, held until `mem_ready`.
  - RESP: `rsp_data`=`old_q`.
- LR: IDLE→RD→RESP.
  - On `mem_ready`: reservation valid=1, `resv_addr`=addr[31:2].
  - `rsp_data`=loaded word.
- SC, decided in IDLE at acceptance:
  - Success (reservation valid and `resv_addr`==addr[31:2]): WR with `mem_wdata`=rs2, then RESP with `rsp_data`=0.
  - Failure: straight to RESP with `rsp_data`=1 and no memory access.
  - Any SC clears the reservation at acceptance, success or fail.
- `resv_clear` clears the reservation in any state. If it coincides with an LR setting the reservation, clear wins.
- AMOs do not touch the reservation.
- `mem_*` outputs are stable while `mem_valid`=1 and `mem_ready`=0.
- `alu_*` outputs are registered and hold their last value outside CALC.

## Timing
- Reset (`resetn`=0 at an edge), values after that edge:
  - state=IDLE; reservation invalid.
  - `req_ready`=0 while `resetn` is low.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
  - `mem_valid`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
  - `alu_a`=0, `alu_b`=0, `alu_ctrl`=ALU_CTRL_ADD_ADDI.
- Reset mid-transaction: abort. `mem_valid` drops the cycle after the reset edge and no response is issued.
- Latencies, acceptance at cycle 0, zero-wait memory (`mem_ready` high in the first cycle of `mem_valid`):
  - AMO: `rsp_valid` at cycle 4 (RD=1, CALC=2, WR=3, RESP=4).
  - LR: cycle 2.
  - SC success: cycle 2.
  - SC fail or error: cycle 1.
- Each memory wait cycle adds 1.
- `req_ready` is 0 from cycle 1 until the cycle after RESP; the earliest back-to-back acceptance is the cycle after `rsp_valid`.
- `rsp_valid` is high exactly one cycle; the consumer needs no backpressure.

## Test plan
- AMOADD: mem[0x100]=5, rs2=7, zero-wait → `rsp_data`=5 at cycle 4; write of 12 to 0x100 with wstrb F; ALU sampled with ctrl ADD, a=5, b=7.
- AMOMIN (signed): mem=0xFFFFFFFE, rs2=3 → written 0xFFFFFFFE, rsp 0xFFFFFFFE. AMOMAXU with the same values → written 0xFFFFFFFE. AMOSWAP with mem=9, rs2=4 → written 4, rsp 9.
- LR 0x200 then SC 0x200 with rs2=0xAA → SC rsp 0 and write 0xAA. A second SC to 0x200 → rsp 1 and no `mem_valid`.
- LR 0x200, pulse `resv_clear`, then SC 0x200 → rsp 1. LR 0x200 then SC 0x204 → rsp 1.
- `mem_ready` delayed 3 cycles in both RD and WR → `mem_addr`/`mem_wdata`/`mem_wstrb` stable throughout, AMO `rsp_valid` at cycle 10. Misaligned addr 0x102 or funct5=00101 → `rsp_err`=1 at cycle 1, no memory access.
- `resetn` low during WR wait → the cycle after the edge `mem_valid`=0 and state IDLE; no `rsp_valid`; a subsequent SC fails (reservation cleared).
